// File: rtl/gfx_cmd_pkg.sv
// Shared definitions for the graphics command dispatcher.
// Holds the opcode map, payload lengths, engine routing and FSM encoding.
package gfx_cmd_pkg;

  localparam int ENG_IDX_W = 2;
  localparam int LEN_W     = 4;

  localparam logic [7:0] OP_FILL_RECT = 8'h01;
  localparam logic [7:0] OP_LINE      = 8'h02;
  localparam logic [7:0] OP_BLIT      = 8'h03;
  localparam logic [7:0] OP_CLEAR     = 8'h04;

  localparam logic [LEN_W-1:0] LEN_FILL_RECT = 4'd11;
  localparam logic [LEN_W-1:0] LEN_LINE      = 4'd10;
  localparam logic [LEN_W-1:0] LEN_BLIT      = 4'd12;
  localparam logic [LEN_W-1:0] LEN_CLEAR     = 4'd3;

  localparam logic [ENG_IDX_W-1:0] ENG_FILL_RECT = 2'd0;
  localparam logic [ENG_IDX_W-1:0] ENG_LINE      = 2'd1;
  localparam logic [ENG_IDX_W-1:0] ENG_BLIT      = 2'd2;
  localparam logic [ENG_IDX_W-1:0] ENG_CLEAR     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_opcode_lut.sv
// Combinational opcode decoder: opcode -> valid flag, engine index, payload length.
// Opcodes routed to an engine that is not instantiated are reported invalid.
module cmd_opcode_lut
  import gfx_cmd_pkg::*;
#(
  parameter int NUM_ENG = 4
) (
  input  logic [7:0]           i_opcode,
  output logic                 o_valid,
  output logic [ENG_IDX_W-1:0] o_eng_idx,
  output logic [LEN_W-1:0]     o_len
);

  logic w_known;

  // opcode table lookup
  always_comb begin
    w_known   = 1'b0;
    o_eng_idx = '0;
    o_len     = '0;
    case (i_opcode)
      OP_FILL_RECT: begin w_known = 1'b1; o_eng_idx = ENG_FILL_RECT; o_len = LEN_FILL_RECT; end
      OP_LINE:      begin w_known = 1'b1; o_eng_idx = ENG_LINE;      o_len = LEN_LINE;      end
      OP_BLIT:      begin w_known = 1'b1; o_eng_idx = ENG_BLIT;      o_len = LEN_BLIT;      end
      OP_CLEAR:     begin w_known = 1'b1; o_eng_idx = ENG_CLEAR;     o_len = LEN_CLEAR;     end
      default:      begin w_known = 1'b0; o_eng_idx = '0;            o_len = '0;            end
    endcase
  end

  assign o_valid = w_known && (int'(o_eng_idx) < NUM_ENG);

endmodule

// File: rtl/cmd_dispatch_arbiter.sv
// Routes opcode-prefixed commands from one byte FIFO to NUM_ENG decode engines,
// holding a one-hot grant from opcode until the selected engine reports done.
module cmd_dispatch_arbiter
  import gfx_cmd_pkg::*;
#(
  parameter int NUM_ENG = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               cmd_fifo_rts,
  input  logic [7:0]         cmd_fifo_data,
  output logic               cmd_fifo_rtr,
  output logic [NUM_ENG-1:0] eng_rts,
  output logic [7:0]         eng_data,
  input  logic [NUM_ENG-1:0] eng_rtr,
  output logic [NUM_ENG-1:0] eng_grant,
  input  logic [NUM_ENG-1:0] eng_done,
  output logic               busy,
  output logic               err_opcode,
  output logic [CNT_W-1:0]   cmd_count
);

  state_e                r_state;
  state_e                w_next_state;
  logic [ENG_IDX_W-1:0]  r_sel;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_cnt;
  logic                  r_pend_done;
  logic                  r_err_opcode;
  logic [CNT_W-1:0]      r_cmd_count;

  logic                  w_lut_valid;
  logic [ENG_IDX_W-1:0]  w_lut_eng;
  logic [LEN_W-1:0]      w_lut_len;
  logic [NUM_ENG-1:0]    w_sel_oh;
  logic                  w_sel_rtr;
  logic                  w_sel_done;
  logic                  w_xfc;
  logic                  w_last_byte;

  cmd_opcode_lut #(.NUM_ENG(NUM_ENG)) u_lut (
    .i_opcode  (cmd_fifo_data),
    .o_valid   (w_lut_valid),
    .o_eng_idx (w_lut_eng),
    .o_len     (w_lut_len)
  );

  // one-hot form of the selected engine index
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      w_sel_oh[i] = (int'(r_sel) == i);
    end
  end

  assign w_sel_rtr   = |(eng_rtr & w_sel_oh);
  assign w_sel_done  = |(eng_done & w_sel_oh);
  assign w_last_byte = (r_cnt == (r_len - 4'd1));
  // transfer decoded from state directly so it does not loop through cmd_fifo_rtr
  assign w_xfc       = cmd_fifo_rts &
                       ((r_state == ST_IDLE) || ((r_state == ST_BUSY) && w_sel_rtr));
  assign eng_data    = cmd_fifo_data;
  assign err_opcode  = r_err_opcode;
  assign cmd_count   = r_cmd_count;

  // next-state and per-state handshake outputs
  always_comb begin
    w_next_state = r_state;
    cmd_fifo_rtr = 1'b0;
    eng_rts      = '0;
    eng_grant    = '0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_fifo_rtr = 1'b1;
        if (w_xfc && w_lut_valid) begin
          w_next_state = ST_BUSY;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cmd_fifo_rtr = w_sel_rtr;
        eng_rts      = w_sel_oh & {NUM_ENG{cmd_fifo_rts}};
        eng_grant    = w_sel_oh;
        busy         = 1'b1;
        if (w_xfc && w_last_byte) begin
          w_next_state = ST_WAIT_DONE;
        end else begin
          w_next_state = ST_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        eng_grant = w_sel_oh;
        busy      = 1'b1;
        if (w_sel_done || r_pend_done) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_DONE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // state, command context, sticky error and completion counter
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_pend_done  <= 1'b0;
      r_err_opcode <= 1'b0;
      r_cmd_count  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_xfc && w_lut_valid) begin
            r_sel       <= w_lut_eng;
            r_len       <= w_lut_len;
            r_cnt       <= '0;
            r_pend_done <= 1'b0;
          end else if (w_xfc) begin
            r_err_opcode <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_xfc) begin
            r_cnt <= r_cnt + 4'd1;
          end
          // an early done is remembered so the command still completes
          if (w_sel_done) begin
            r_pend_done <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (w_sel_done || r_pend_done) begin
            r_cmd_count <= r_cmd_count + CNT_W'(1);
            r_pend_done <= 1'b0;
          end
        end
        default: begin
          r_pend_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
